// File: rtl/present_mask_pkg.sv
// Shared constants, FSM state type and the PRESENT S-box lookup for the
// masked substitution-layer controller.
//   NIB     nibbles per state (state width 4*NIB)
//   SB_LAT  cycles from S-box input to S-box output
//   R_OFS   cycles from nibble presentation to refresh-randomness use
//   RW      randomness bits per S-box evaluation
package present_mask_pkg;

    localparam int NIB     = 16;
    localparam int SB_LAT  = 4;
    localparam int R_OFS   = 2;
    localparam int RW      = 8;
    localparam int STATE_W = 4 * NIB;
    localparam int IDX_W   = $clog2(NIB);
    localparam int CNT_W   = $clog2(NIB + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } layer_state_e;

    // Unmasked PRESENT S-box; reference for behavioural models.
    function automatic logic [3:0] present_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mask_rnd_delay.sv
// Delay line for S-box refresh randomness. A word pushed in cycle t is
// presented on dout in cycle t+R_OFS; cycles without a push carry zero.
//   clk, rst_n  clock, asynchronous active-low reset
//   push        a PRNG word is popped this cycle
//   din         popped PRNG word
//   dout        delayed word (zero for bubble cycles)
module mask_rnd_delay
    import present_mask_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [RW-1:0] din,
    output logic [RW-1:0] dout
);

    logic [RW-1:0] stage [R_OFS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < R_OFS; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // Zero fill on bubbles so a word can never be presented twice.
            stage[0] <= push ? din : '0;
            for (int i = 1; i < R_OFS; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[R_OFS-1];

endmodule

// File: rtl/present_sbox_layer_ctrl.sv
// Sequences one PRESENT substitution layer on a 3-share masked 64-bit state
// through a single external masked S-box, one nibble per cycle.
//   s_valid/s_ready, s_sh1..3     input state handshake and shares
//   rnd_valid/rnd_ready, rnd_data PRNG word handshake (one word per nibble)
//   sb_in1..3, sb_r               S-box input shares and refresh randomness
//   sb_out1..3                    S-box output shares (SB_LAT after input)
//   m_valid/m_ready, m_sh1..3     substituted state handshake and shares
module present_sbox_layer_ctrl
    import present_mask_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [STATE_W-1:0] s_sh1,
    input  logic [STATE_W-1:0] s_sh2,
    input  logic [STATE_W-1:0] s_sh3,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    input  logic [RW-1:0]      rnd_data,
    output logic [3:0]         sb_in1,
    output logic [3:0]         sb_in2,
    output logic [3:0]         sb_in3,
    output logic [RW-1:0]      sb_r,
    input  logic [3:0]         sb_out1,
    input  logic [3:0]         sb_out2,
    input  logic [3:0]         sb_out3,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [STATE_W-1:0] m_sh1,
    output logic [STATE_W-1:0] m_sh2,
    output logic [STATE_W-1:0] m_sh3
);

    layer_state_e       state, state_nxt;
    logic [STATE_W-1:0] buf1, buf2, buf3;
    logic [CNT_W-1:0]   issue_cnt, capture_cnt;
    logic [SB_LAT-1:0]  vld_pipe;
    logic               accept, issue, capture;
    logic [IDX_W-1:0]   issue_idx, capture_idx;

    assign accept      = s_valid & s_ready;
    assign issue       = rnd_valid & rnd_ready;
    assign capture     = vld_pipe[SB_LAT-1];
    assign issue_idx   = issue_cnt[IDX_W-1:0];
    assign capture_idx = capture_cnt[IDX_W-1:0];

    always_comb begin
        state_nxt = state;
        rnd_ready = 1'b0;
        m_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                rnd_ready = (issue_cnt < CNT_W'(NIB));
                if (capture && (capture_cnt == CNT_W'(NIB - 1))) state_nxt = DONE;
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // s_ready is registered so it reads 0 while reset is held and for the
    // first cycle after release, and 1 the cycle after every return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            issue_cnt   <= '0;
            capture_cnt <= '0;
            vld_pipe    <= '0;
        end else begin
            state    <= state_nxt;
            s_ready  <= (state_nxt == IDLE);
            vld_pipe <= {vld_pipe[SB_LAT-2:0], issue};
            if (accept) begin
                issue_cnt   <= '0;
                capture_cnt <= '0;
            end else begin
                if (issue)   issue_cnt   <= issue_cnt + 1'b1;
                if (capture) capture_cnt <= capture_cnt + 1'b1;
            end
        end
    end

    // Each share lives in its own register and only ever meets its own
    // S-box port; shares are never combined anywhere in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf1  <= '0;
            buf2  <= '0;
            buf3  <= '0;
            m_sh1 <= '0;
            m_sh2 <= '0;
            m_sh3 <= '0;
        end else begin
            if (accept) begin
                buf1 <= s_sh1;
                buf2 <= s_sh2;
                buf3 <= s_sh3;
            end
            if (capture) begin
                m_sh1[{capture_idx, 2'b00} +: 4] <= sb_out1;
                m_sh2[{capture_idx, 2'b00} +: 4] <= sb_out2;
                m_sh3[{capture_idx, 2'b00} +: 4] <= sb_out3;
            end
        end
    end

    // Bubble cycles present all-zero shares to the S-box.
    assign sb_in1 = issue ? buf1[{issue_idx, 2'b00} +: 4] : 4'h0;
    assign sb_in2 = issue ? buf2[{issue_idx, 2'b00} +: 4] : 4'h0;
    assign sb_in3 = issue ? buf3[{issue_idx, 2'b00} +: 4] : 4'h0;

    mask_rnd_delay u_rnd_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue),
        .din   (rnd_data),
        .dout  (sb_r)
    );

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
`timescale 1ns/1ps
module tb_present_sbox_layer_ctrl;
    import present_mask_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid, s_ready;
    logic [63:0] s_sh1, s_sh2, s_sh3;
    logic        rnd_valid = 1'b0, rnd_ready;
    logic [7:0]  rnd_data = 8'h0;
    logic [3:0]  sb_in1, sb_in2, sb_in3;
    logic [7:0]  sb_r;
    logic [3:0]  sb_out1 = 4'h0, sb_out2 = 4'h0, sb_out3 = 4'h0;
    logic        m_valid, m_ready;
    logic [63:0] m_sh1, m_sh2, m_sh3;

    present_sbox_layer_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_sh1(s_sh1), .s_sh2(s_sh2), .s_sh3(s_sh3),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r(sb_r),
        .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_sh1(m_sh1), .m_sh2(m_sh2), .m_sh3(m_sh3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unmasked substitution layer applied nibble by nibble.
    function automatic logic [63:0] layer_ref(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = present_sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Scoreboard and monitor state
    logic [63:0] exp_q[$];
    bit          busy = 0, mv_seen = 0, sready_chk = 0;
    int          acc_cyc = 0, acc_cnt = 0, hs_cnt = 0, hs_cyc = 0;
    int          pops = 0, stalls = 0, rise_rel = 0, rise_pops = 0;
    logic [63:0] cur1, cur2, cur3, hold1, hold2, hold3;
    logic [11:0] hist [8];
    logic [7:0]  rwd [8];
    logic        m_exp_rr, m_pop;
    logic [3:0]  m_x, m_o2, m_o3;

    // Stimulus side drivers for PRNG and optional random back-pressure
    int rmode = 0;
    bit rand_mr = 0;
    always @(posedge clk) begin
        #1;
        rnd_data = 8'($urandom);
        case (rmode)
            0: rnd_valid = 1'b1;
            1: rnd_valid = !(busy && (cyc - acc_cyc) >= 5 && (cyc - acc_cyc) <= 7);
            default: rnd_valid = ($urandom_range(3) != 0);
        endcase
        if (rand_mr) m_ready = 1'($urandom_range(1));
    end

    // Monitor: emulates a masked S-box with SB_LAT latency and checks the
    // controller's observable behaviour on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0; mv_seen = 0; sready_chk = 0; pops = 0; stalls = 0;
            for (int i = 0; i < 8; i++) begin hist[i] = '0; rwd[i] = '0; end
        end else begin
            hist[cyc % 8] = {sb_in1, sb_in2, sb_in3};
            m_x  = hist[(cyc + 4) % 8][11:8] ^ hist[(cyc + 4) % 8][7:4] ^ hist[(cyc + 4) % 8][3:0];
            m_o2 = 4'($urandom);
            m_o3 = 4'($urandom);
            sb_out2 = m_o2;
            sb_out3 = m_o3;
            sb_out1 = present_sbox(m_x) ^ m_o2 ^ m_o3;

            if (sready_chk) begin
                chk("s_ready_after_handshake", s_ready, 1);
                sready_chk = 0;
            end
            if (busy) chk("s_ready_busy", s_ready, 0);

            m_exp_rr = busy && (cyc > acc_cyc) && (pops < 16);
            chk("rnd_ready", rnd_ready, m_exp_rr);
            m_pop = m_exp_rr && rnd_valid;
            chk("sb_r", sb_r, rwd[(cyc + 6) % 8]);
            rwd[cyc % 8] = m_pop ? rnd_data : 8'h0;
            if (m_pop) begin
                chk("sb_in1", sb_in1, cur1[4*pops +: 4]);
                chk("sb_in2", sb_in2, cur2[4*pops +: 4]);
                chk("sb_in3", sb_in3, cur3[4*pops +: 4]);
                pops++;
            end else begin
                chk("sb_in_bubble", {sb_in1, sb_in2, sb_in3}, 0);
                if (m_exp_rr) stalls++;
            end

            chk("m_valid", m_valid, busy && ((cyc - acc_cyc) >= 21 + stalls));
            if (m_valid && !mv_seen) begin
                mv_seen = 1;
                rise_rel = cyc - acc_cyc;
                rise_pops = pops;
                hold1 = m_sh1; hold2 = m_sh2; hold3 = m_sh3;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL result: output %h with no expected entry", m_sh1 ^ m_sh2 ^ m_sh3);
                end else begin
                    chk("result", m_sh1 ^ m_sh2 ^ m_sh3, exp_q.pop_front());
                end
            end else if (m_valid) begin
                chk("m_sh1_hold", m_sh1, hold1);
                chk("m_sh2_hold", m_sh2, hold2);
                chk("m_sh3_hold", m_sh3, hold3);
            end
            if (m_valid && m_ready) begin
                busy = 0; mv_seen = 0; hs_cnt++; hs_cyc = cyc; sready_chk = 1;
            end
            if (s_valid && s_ready && !busy) begin
                busy = 1; acc_cyc = cyc; acc_cnt++; pops = 0; stalls = 0;
                cur1 = s_sh1; cur2 = s_sh2; cur3 = s_sh3;
            end
        end
    end

    task automatic present(input logic [63:0] x, input logic [63:0] s2,
                           input logic [63:0] s3, input logic [63:0] exp);
        int a0, n;
        s_sh2 = s2; s_sh3 = s3; s_sh1 = x ^ s2 ^ s3; s_valid = 1'b1;
        exp_q.push_back(exp);
        a0 = acc_cnt; n = 0;
        while (acc_cnt == a0 && n < 200) begin @(posedge clk); n++; end
        #1;
        if (acc_cnt == a0) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic wait_hs(input int budget);
        int h0, n;
        h0 = hs_cnt; n = 0;
        while (hs_cnt == h0 && n < budget) begin @(posedge clk); n++; end
        #1;
        if (hs_cnt == h0) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: got none expected handshake within %0d cycles", budget);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_rnd_ready"}, rnd_ready, 0);
        chk({tag, "_sb_r"}, sb_r, 0);
        chk({tag, "_sb_in"}, {sb_in1, sb_in2, sb_in3}, 0);
        chk({tag, "_m_sh1"}, m_sh1, 0);
        chk({tag, "_m_sh2"}, m_sh2, 0);
        chk({tag, "_m_sh3"}, m_sh3, 0);
    endtask

    initial begin
        logic [63:0] x;
        int n;
        s_valid = 1'b0; s_sh1 = '0; s_sh2 = '0; s_sh3 = '0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known vector, no stalls
        present(64'h0123456789ABCDEF, rand64(), rand64(), 64'hC56B90AD3EF84712);
        s_valid = 1'b0;
        wait_hs(200);
        chk("t1_latency", rise_rel, 21);
        chk("t1_pops", rise_pops, 16);

        // Same vector with a three-cycle PRNG stall
        rmode = 1;
        present(64'h0123456789ABCDEF, rand64(), rand64(), 64'hC56B90AD3EF84712);
        s_valid = 1'b0;
        wait_hs(200);
        chk("t2_latency", rise_rel, 24);
        chk("t2_pops", rise_pops, 16);
        rmode = 0;

        // Only share 1 carries data
        present(64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h2222222222222222);
        s_valid = 1'b0;
        wait_hs(200);

        // Held output under back-pressure
        m_ready = 1'b0;
        x = rand64();
        present(x, rand64(), rand64(), layer_ref(x));
        s_valid = 1'b0;
        n = 0;
        while (!mv_seen && n < 200) begin @(posedge clk); n++; end
        if (!mv_seen) begin
            checks++; failures++;
            $display("FAIL m_valid_timeout: got none expected m_valid within 200 cycles");
        end
        repeat (10) @(posedge clk);
        #1;
        chk("bp_m_valid", m_valid, 1);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_rnd_ready", rnd_ready, 0);
        m_ready = 1'b1;
        wait_hs(5);

        // Asynchronous reset in cycle 9 of a run
        x = rand64();
        present(x, rand64(), rand64(), layer_ref(x));
        s_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        x = rand64();
        present(x, rand64(), rand64(), layer_ref(x));
        s_valid = 1'b0;
        wait_hs(200);
        chk("post_rst_latency", rise_rel, 21);

        // Back-to-back with s_valid held high
        x = rand64();
        present(x, rand64(), rand64(), layer_ref(x));
        x = rand64();
        present(x, rand64(), rand64(), layer_ref(x));
        chk("b2b_accept_cycle", acc_cyc, hs_cyc + 1);
        s_valid = 1'b0;
        wait_hs(200);

        // Random PRNG stalls and random back-pressure
        rmode = 2;
        rand_mr = 1;
        for (int i = 0; i < 8; i++) begin
            x = rand64();
            present(x, rand64(), rand64(), layer_ref(x));
            s_valid = 1'b0;
            wait_hs(400);
        end
        rand_mr = 0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
